// File: rtl/block_slider_pkg.sv
// Shared constants and state type for the block slider and its helpers.
package block_pkg;

    localparam int POS_W   = 9;
    localparam int SIZE_W  = 4;
    // Internal position width: one bit wider so end + step never wraps.
    localparam int ARITH_W = 10;

    typedef enum logic [1:0] {
        IDLE,
        MOVE,
        CHECK,
        OVER
    } slider_state_t;

endpackage

// File: rtl/block_slider_if.sv
// Bus between the input/tracker logic (master) and the block slider (slave).
interface block_slider_if;
    import block_pkg::*;

    logic              start;
    logic              tick;
    logic              stop_btn;
    logic [POS_W-1:0]  prev_block_start;
    logic [POS_W-1:0]  prev_block_end;
    logic [SIZE_W-1:0] prev_block_size;
    logic [POS_W-1:0]  curr_block_start;
    logic [POS_W-1:0]  curr_block_end;
    logic [SIZE_W-1:0] curr_block_size;
    logic              stop_true;
    logic              intersect_true;
    logic              moving;
    logic              game_over;

    modport master (
        output start, tick, stop_btn,
        output prev_block_start, prev_block_end, prev_block_size,
        input  curr_block_start, curr_block_end, curr_block_size,
        input  stop_true, intersect_true, moving, game_over
    );

    modport slave (
        input  start, tick, stop_btn,
        input  prev_block_start, prev_block_end, prev_block_size,
        output curr_block_start, curr_block_end, curr_block_size,
        output stop_true, intersect_true, moving, game_over
    );

endinterface

// File: rtl/block_slider_overlap.sv
// Combinational overlap of the moving block with the placed block.
// With no placed block (prev_size 0) the moving block counts as a full hit.
module block_overlap
    import block_pkg::*;
#(
    parameter int CELL_SHIFT = 4
) (
    input  logic [POS_W-1:0]  curr_start,
    input  logic [POS_W-1:0]  curr_end,
    input  logic [POS_W-1:0]  prev_start,
    input  logic [POS_W-1:0]  prev_end,
    input  logic [SIZE_W-1:0] prev_size,
    output logic [POS_W-1:0]  lo,
    output logic [POS_W-1:0]  hi,
    output logic [SIZE_W-1:0] size,
    output logic              hit
);

    logic [ARITH_W-1:0] span;

    always_comb begin
        lo   = curr_start;
        hi   = curr_end;
        size = '0;
        hit  = 1'b0;
        span = '0;
        if (prev_size == '0) begin
            hit = 1'b1;
        end else begin
            lo  = (curr_start > prev_start) ? curr_start : prev_start;
            hi  = (curr_end < prev_end) ? curr_end : prev_end;
            hit = (lo <= hi);
        end
        // Cell-aligned edges make this shift exact.
        if (hit) begin
            span = {1'b0, hi} - {1'b0, lo} + ARITH_W'(1);
            size = SIZE_W'(span >> CELL_SHIFT);
        end
    end

endmodule

// File: rtl/block_slider.sv
// Moving-block controller: slides the block, trims it on stop and reports placement.
// Optional BLOCK_SLIDER_SPEEDUP_EN: level counter that slows moves to one per (8 - level) ticks.
module block_slider
    import block_pkg::*;
#(
    parameter int SCREEN_W   = 320,
    parameter int CELL_SHIFT = 4,
    parameter int INIT_SIZE  = 4
) (
    input logic           clk,
    input logic           reset,
    block_slider_if.slave bus
);

    localparam logic [ARITH_W-1:0] STEP        = ARITH_W'(1 << CELL_SHIFT);
    localparam logic [ARITH_W-1:0] RIGHT_LIMIT = ARITH_W'(SCREEN_W - 1);

    slider_state_t     state, state_next;
    logic              dir, dir_next;
    logic [POS_W-1:0]  blk_start, blk_start_next;
    logic [POS_W-1:0]  blk_end, blk_end_next;
    logic [SIZE_W-1:0] blk_size, blk_size_next;
    logic              stop_r, stop_next;
    logic              hit_r, hit_next;
    logic              over_r, over_next;
    logic              move_event;

    logic [POS_W-1:0]   ov_lo, ov_hi;
    logic [SIZE_W-1:0]  ov_size;
    logic               ov_hit;
    logic [SIZE_W-1:0]  new_size;
    logic [ARITH_W-1:0] new_end;
    logic [ARITH_W-1:0] s10, e10;
    logic               fits_right, fits_left;

    block_overlap #(.CELL_SHIFT(CELL_SHIFT)) u_overlap (
        .curr_start (blk_start),
        .curr_end   (blk_end),
        .prev_start (bus.prev_block_start),
        .prev_end   (bus.prev_block_end),
        .prev_size  (bus.prev_block_size),
        .lo         (ov_lo),
        .hi         (ov_hi),
        .size       (ov_size),
        .hit        (ov_hit)
    );

    assign new_size   = (bus.prev_block_size == '0) ? SIZE_W'(INIT_SIZE) : bus.prev_block_size;
    assign new_end    = (ARITH_W'(new_size) << CELL_SHIFT) - ARITH_W'(1);
    assign s10        = {1'b0, blk_start};
    assign e10        = {1'b0, blk_end};
    assign fits_right = (e10 + STEP) <= RIGHT_LIMIT;
    assign fits_left  = (s10 >= STEP);

`ifdef BLOCK_SLIDER_SPEEDUP_EN
    logic [2:0] level, level_next;
    logic [2:0] presc, presc_next;

    // Count ticks and release a move event once every (8 - level) of them.
    always_comb begin
        level_next = level;
        presc_next = presc;
        move_event = 1'b0;
        if (state == IDLE && bus.start) begin
            presc_next = '0;
        end else if (state == MOVE && !bus.stop_btn && bus.tick) begin
            if ({1'b0, presc} + 4'd1 >= 4'd8 - {1'b0, level}) begin
                move_event = 1'b1;
                presc_next = '0;
            end else begin
                presc_next = presc + 3'd1;
            end
        end
        if (state == CHECK && ov_hit && level != 3'd7) begin
            level_next = level + 3'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            level <= '0;
            presc <= '0;
        end else begin
            level <= level_next;
            presc <= presc_next;
        end
    end
`else
    assign move_event = bus.tick;
`endif

    always_comb begin
        state_next     = state;
        dir_next       = dir;
        blk_start_next = blk_start;
        blk_end_next   = blk_end;
        blk_size_next  = blk_size;
        stop_next      = 1'b0;
        hit_next       = 1'b0;
        over_next      = over_r;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    blk_start_next = '0;
                    blk_end_next   = POS_W'(new_end);
                    blk_size_next  = new_size;
                    dir_next       = 1'b0;
                    state_next     = MOVE;
                end
            end
            MOVE: begin
                // Stop wins over a same-cycle move; a block that fits nowhere holds.
                if (bus.stop_btn) begin
                    state_next = CHECK;
                end else if (move_event) begin
                    if ((!dir && fits_right) || (dir && !fits_left && fits_right)) begin
                        dir_next       = 1'b0;
                        blk_start_next = POS_W'(s10 + STEP);
                        blk_end_next   = POS_W'(e10 + STEP);
                    end else if (fits_left) begin
                        dir_next       = 1'b1;
                        blk_start_next = POS_W'(s10 - STEP);
                        blk_end_next   = POS_W'(e10 - STEP);
                    end
                end
            end
            CHECK: begin
                stop_next = 1'b1;
                hit_next  = ov_hit;
                if (ov_hit) begin
                    blk_start_next = ov_lo;
                    blk_end_next   = ov_hi;
                    blk_size_next  = ov_size;
                    state_next     = IDLE;
                end else begin
                    blk_size_next = '0;
                    over_next     = 1'b1;
                    state_next    = OVER;
                end
            end
            OVER: begin
                state_next = OVER;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            dir       <= 1'b0;
            blk_start <= '0;
            blk_end   <= '0;
            blk_size  <= '0;
            stop_r    <= 1'b0;
            hit_r     <= 1'b0;
            over_r    <= 1'b0;
        end else begin
            state     <= state_next;
            dir       <= dir_next;
            blk_start <= blk_start_next;
            blk_end   <= blk_end_next;
            blk_size  <= blk_size_next;
            stop_r    <= stop_next;
            hit_r     <= hit_next;
            over_r    <= over_next;
        end
    end

    assign bus.curr_block_start = blk_start;
    assign bus.curr_block_end   = blk_end;
    assign bus.curr_block_size  = blk_size;
    assign bus.stop_true        = stop_r;
    assign bus.intersect_true   = hit_r;
    assign bus.game_over        = over_r;
    assign bus.moving           = (state == MOVE);

endmodule

// File: doc/block_slider.md
# block_slider

- Drives the moving block for each new row and reports its placement to the block tracker.
- On a stop request it computes the overlap with the previously placed block and trims the block to that overlap.
- It then issues the one-cycle `stop_true`/`intersect_true` report with the trimmed `curr_block_*` values.
- Sits between the input/rate-divider logic and the tracker; the tracker's `prev_block_*` outputs feed back in here.

## Interface
- `SCREEN_W`, 320: playfield width in pixels.
- `CELL_SHIFT`, 4: log2 of the cell width in pixels (cell width 16). This is also the movement step.
- `INIT_SIZE`, 4: block size in cells used when there is no previous block.
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  pulse; begins a new row.
- `tick`  in  1  movement-rate pulse, one cycle wide.
- `stop_btn`  in  1  pulse; player stop request, already synchronized.
- `prev_block_start`  in  9  left pixel of the placed block.
- `prev_block_end`  in  9  right pixel (inclusive) of the placed block.
- `prev_block_size`  in  4  size of the placed block in cells; 0 means none.
- `curr_block_start`  out  9  left pixel of the current block.
- `curr_block_end`  out  9  right pixel (inclusive) of the current block.
- `curr_block_size`  out  4  size of the current block in cells.
- `stop_true`  out  1  one-cycle placement report.
- `intersect_true`  out  1  overlap flag; valid while `stop_true` is high.
- `moving`  out  1  high while in MOVE.
- `game_over`  out  1  sticky miss flag.

## Operation
**States:** IDLE, MOVE, CHECK, OVER. Direction register `dir`: 0 = right, 1 = left.

**Reset values:**
- All `curr_*` outputs 0.
- `stop_true`, `intersect_true`, `game_over` all 0.
- State IDLE, `dir` 0.

**IDLE**, on `start`:
- Size = `INIT_SIZE` if `prev_block_size` == 0, else `prev_block_size`.
- Start = 0; end = (size << `CELL_SHIFT`) − 1; `dir` = 0.
- Go to MOVE.

**MOVE**, on a move event (each `tick`; see Configuration), with step = 1 << `CELL_SHIFT`:
- `dir` = 0 and end + step ≤ `SCREEN_W` − 1: start and end each increase by step.
- `dir` = 0 and the edge would be crossed: set `dir` = 1 and move left by step in the same cycle.
- `dir` = 1 and start ≥ step: move left by step.
- `dir` = 1 and start < step: set `dir` = 0 and move right by step.
- A block that fits in neither direction holds its position.

**MOVE**, on `stop_btn`: go to CHECK. `stop_btn` takes priority over a same-cycle `tick`; the block does not move that cycle.

**CHECK** (one cycle):
- lo = max(start, `prev_block_start`); hi = min(end, `prev_block_end`).
- If `prev_block_size` == 0, treat the placement as a full intersect with the block unchanged.
- Otherwise, lo ≤ hi is an intersect: start = lo, end = hi, size = (hi − lo + 1) >> `CELL_SHIFT`.
- Otherwise it is a miss: size = 0, start and end unchanged, `game_over` = 1.
- Either way, `stop_true` pulses with `intersect_true` = the result.
- Next state: IDLE on an intersect, OVER on a miss.

**OVER:** `start`, `tick` and `stop_btn` are ignored. Only `reset` exits.

**Ignored inputs:**
- `stop_btn` in IDLE or OVER.
- `start` in MOVE or CHECK.

**Arithmetic:**
- All position arithmetic is 10 bits internally so that end + step cannot wrap.
- Positions stay cell-aligned, so the size shift is exact.

## Timing
- `stop_btn` sampled at edge k moves the state to CHECK.
- At edge k+1 the `curr_*` values update, `stop_true` = 1, and `intersect_true` is valid.
- At edge k+2 `stop_true` returns to 0.
- `start` at edge k gives new `curr_*` values and `moving` = 1 after edge k.
- `tick` at edge k gives a new position after edge k.
- `reset` asserted mid-CHECK or mid-MOVE forces all reset values immediately, with no completion pulse.

## Configuration
- `BLOCK_SLIDER_SPEEDUP_EN` defined:
  - 3-bit `level` counter, reset 0, incremented on each intersect and saturating at 7.
  - A move event occurs every (8 − `level`) ticks.
  - The prescaler reloads on `start`.
- Not defined: every `tick` is a move event and no level logic exists.

## Structure
- **Shared package `block_pkg`:**
  - Constants `POS_W` = 9 and `SIZE_W` = 4.
  - State enum `slider_state_t` {IDLE, MOVE, CHECK, OVER}.
- **Sub-module `block_overlap`:** combinational.
  - Inputs: curr start/end and prev start/end/size.
  - Outputs: lo, hi, size, hit.
  - It is reused by any future scoring logic.

## Test plan
1. Reset, `prev_block_size` = 0, `start` → `curr_block_start` 0, `curr_block_end` 63, `curr_block_size` 4, `moving` 1.
2. From (1), 3 ticks → start 48, end 111.
3. From (1), 16 ticks → start 256, end 319; 17th tick → start 240, `dir` left.
4. prev 32..95 size 4, curr 64..127, `stop_btn` → one cycle later `stop_true` 1, `intersect_true` 1, curr 64..95 size 2; state IDLE.
5. prev 0..63, curr 128..191, `stop_btn` → `intersect_true` 0, size 0, `game_over` 1; a later `start` is ignored.
6. `stop_btn` and `tick` in the same cycle → no move, CHECK entered; `reset` pulsed during CHECK → no `stop_true`, all outputs 0.
